// File: rtl/touch_pkg.sv
// Shared types and constants for the resistive-touch ADC front end.
package touch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_CONV,
        ST_GAP,
        ST_FLUSH
    } touch_state_t;

    localparam logic [7:0] CMD_X      = 8'hD0;
    localparam logic [7:0] CMD_Y      = 8'h90;
    localparam int         XFER_CLKS  = 24;
    localparam int         DATA_FIRST = 10;
    localparam int         DATA_LAST  = 21;

    // Even slots sample X, odd slots sample Y.
    function automatic logic [7:0] slot_cmd(input logic y_slot);
        return y_slot ? CMD_Y : CMD_X;
    endfunction

endpackage

// File: rtl/touch_spi_xfer.sv
// One 24-DCLK SPI transaction: 8 command bits out, 12 result bits in.
module touch_spi_xfer
    import touch_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic        sys_clk,
    input  logic        iRST_n,
    input  logic        start,
    input  logic [7:0]  cmd,
    output logic        done,
    output logic [11:0] result,
    input  logic        adc_dout,
    output logic        adc_dclk,
    output logic        adc_cs_n,
    output logic        adc_din
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div_cnt;
    logic [5:0]    half_cnt;
    logic [5:0]    rise_num;
    logic [6:0]    cmd_sh;
    logic [11:0]   rx_sh;
    logic          div_end;

    assign div_end  = (div_cnt == DW'(CLK_DIV - 1));
    assign rise_num = {1'b0, half_cnt[5:1]} + 6'd1;
    assign result   = rx_sh;

    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            adc_dclk <= 1'b0;
            adc_cs_n <= 1'b1;
            adc_din  <= 1'b0;
            done     <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            cmd_sh   <= '0;
            rx_sh    <= '0;
        end else begin
            done <= 1'b0;
            if (adc_cs_n) begin
                if (start) begin
                    adc_cs_n <= 1'b0;
                    adc_din  <= cmd[7];
                    cmd_sh   <= cmd[6:0];
                    div_cnt  <= '0;
                    half_cnt <= '0;
                    adc_dclk <= 1'b0;
                end
            end else if (div_end) begin
                div_cnt <= '0;
                if (half_cnt == 6'(2*XFER_CLKS - 1)) begin
                    adc_cs_n <= 1'b1;
                    adc_dclk <= 1'b0;
                    adc_din  <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    half_cnt <= half_cnt + 6'd1;
                    adc_dclk <= ~adc_dclk;
                    if (!adc_dclk) begin
                        // Rising edge: the ADC has held this bit since the previous fall.
                        if (rise_num >= 6'(DATA_FIRST) && rise_num <= 6'(DATA_LAST))
                            rx_sh <= {rx_sh[10:0], adc_dout};
                    end else begin
                        // Falling edge: zeros shift in, so DIN idles low after edge 8.
                        adc_din <= cmd_sh[6];
                        cmd_sh  <= {cmd_sh[5:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/touch_adc_ctrl.sv
// Touch ADC sequencer: debounce, 8-slot X/Y conversion frames, 4-sample averaging, release detect.
module touch_adc_ctrl
    import touch_pkg::*;
#(
    parameter int          CLK_DIV  = 25,
    parameter logic [19:0] DEBOUNCE = 20'd500000,
    parameter logic [15:0] RELEASE  = 16'd50000,
    parameter logic [15:0] GAP      = 16'd2000
) (
    input  logic       sys_clk,
    input  logic       iRST_n,
    input  logic       adc_penirq_n,
    input  logic       adc_dout,
    output logic       adc_dclk,
    output logic       adc_cs_n,
    output logic       adc_din,
    output logic [7:0] x_coord,
    output logic [9:0] y_coord,
    output logic       new_coord,
    output logic       penirq_n,
    output logic       transmit_en
);

    touch_state_t state;
    logic        pen_meta, pen_sync;
    logic [19:0] db_cnt;
    logic [15:0] gap_cnt, up_cnt, idle_cnt;
    logic [2:0]  slot;
    logic [13:0] acc_x, acc_y, x_sum, y_sum;
    logic        in_xfer, xfer_start, xfer_done;
    logic [11:0] xfer_result;

    assign penirq_n   = pen_sync;
    assign x_sum      = acc_x + {2'b00, xfer_result};
    assign y_sum      = acc_y + {2'b00, xfer_result};
    assign xfer_start = (state == ST_CONV) && !in_xfer && (idle_cnt == 16'd0);

    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            pen_meta <= 1'b1;
            pen_sync <= 1'b1;
        end else begin
            pen_meta <= adc_penirq_n;
            pen_sync <= pen_meta;
        end
    end

    touch_spi_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
        .sys_clk  (sys_clk),
        .iRST_n   (iRST_n),
        .start    (xfer_start),
        .cmd      (slot_cmd(slot[0])),
        .done     (xfer_done),
        .result   (xfer_result),
        .adc_dout (adc_dout),
        .adc_dclk (adc_dclk),
        .adc_cs_n (adc_cs_n),
        .adc_din  (adc_din)
    );

    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            state       <= ST_IDLE;
            db_cnt      <= '0;
            gap_cnt     <= '0;
            up_cnt      <= '0;
            idle_cnt    <= '0;
            slot        <= '0;
            acc_x       <= '0;
            acc_y       <= '0;
            in_xfer     <= 1'b0;
            x_coord     <= '0;
            y_coord     <= '0;
            new_coord   <= 1'b0;
            transmit_en <= 1'b0;
        end else begin
            new_coord <= 1'b0;
            case (state)
                ST_IDLE: begin
                    db_cnt <= '0;
                    if (!pen_sync) state <= ST_DEBOUNCE;
                end
                ST_DEBOUNCE: begin
                    if (pen_sync) begin
                        state <= ST_IDLE;
                    end else if (db_cnt == DEBOUNCE - 20'd1) begin
                        transmit_en <= 1'b1;
                        acc_x       <= '0;
                        acc_y       <= '0;
                        slot        <= '0;
                        up_cnt      <= '0;
                        idle_cnt    <= '0;
                        in_xfer     <= 1'b0;
                        state       <= ST_CONV;
                    end else begin
                        db_cnt <= db_cnt + 20'd1;
                    end
                end
                ST_CONV: begin
                    if (!in_xfer) begin
                        if (idle_cnt == 16'd0) in_xfer <= 1'b1;
                        else                   idle_cnt <= idle_cnt - 16'd1;
                    end else if (xfer_done) begin
                        in_xfer <= 1'b0;
                        if (slot[0]) acc_y <= y_sum;
                        else         acc_x <= x_sum;
                        if (slot == 3'd7) begin
                            // Slot 7 is a Y sample, so Y publishes from the fresh sum.
                            x_coord   <= 8'(acc_x >> 6);
                            y_coord   <= 10'(y_sum >> 4);
                            new_coord <= 1'b1;
                            acc_x     <= '0;
                            acc_y     <= '0;
                            slot      <= '0;
                            gap_cnt   <= '0;
                            state     <= ST_GAP;
                        end else begin
                            slot     <= slot + 3'd1;
                            idle_cnt <= 16'(2*CLK_DIV - 2);
                        end
                    end
                end
                ST_GAP: begin
                    // Up-count spans gaps: a release must be contiguous across frames.
                    up_cnt <= pen_sync ? up_cnt + 16'd1 : 16'd0;
                    if (pen_sync && up_cnt == RELEASE - 16'd1) begin
                        state <= ST_FLUSH;
                    end else if (gap_cnt == GAP - 16'd1) begin
                        idle_cnt <= '0;
                        in_xfer  <= 1'b0;
                        state    <= ST_CONV;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                ST_FLUSH: begin
                    transmit_en <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_touch_adc_ctrl.sv
// Scoreboard bench for touch_adc_ctrl with a behavioural AD7843-style ADC model.
module tb_touch_adc_ctrl;

    localparam int          CLK_DIV = 2;
    localparam logic [19:0] DEB     = 20'd100;
    localparam logic [15:0] REL     = 16'd100;
    localparam logic [15:0] GAPC    = 16'd200;

    logic       sys_clk = 1'b0;
    logic       iRST_n = 1'b0;
    logic       adc_penirq_n = 1'b1;
    logic       adc_dout = 1'b0;
    logic       adc_dclk, adc_cs_n, adc_din, new_coord, penirq_n, transmit_en;
    logic [7:0] x_coord;
    logic [9:0] y_coord;

    touch_adc_ctrl #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEB), .RELEASE(REL), .GAP(GAPC)) dut (
        .sys_clk(sys_clk), .iRST_n(iRST_n), .adc_penirq_n(adc_penirq_n), .adc_dout(adc_dout),
        .adc_dclk(adc_dclk), .adc_cs_n(adc_cs_n), .adc_din(adc_din),
        .x_coord(x_coord), .y_coord(y_coord), .new_coord(new_coord),
        .penirq_n(penirq_n), .transmit_en(transmit_en)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    typedef struct packed { logic [7:0] x; logic [9:0] y; } coord_t;
    coord_t     exp_q[$];
    logic [7:0] cmd_q[$];

    task automatic push_frame(input logic [7:0] x, input logic [9:0] y);
        coord_t c;
        c.x = x;
        c.y = y;
        exp_q.push_back(c);
        for (int i = 0; i < 4; i++) begin
            cmd_q.push_back(8'hD0);
            cmd_q.push_back(8'h90);
        end
    endtask

    // Coordinate monitor
    int nc_seen = 0;
    int last_nc_cyc = 0;
    always @(negedge sys_clk) begin
        coord_t e;
        if (new_coord) begin
            nc_seen++;
            last_nc_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_new_coord: got x=0x%0h y=0x%0h, expected no strobe", x_coord, y_coord);
            end else begin
                e = exp_q.pop_front();
                chk("x_coord", 32'(x_coord), 32'(e.x));
                chk("y_coord", 32'(y_coord), 32'(e.y));
                chk("transmit_en_at_coord", 32'(transmit_en), 1);
            end
        end
    end

    // ADC model: decodes the command, returns per-type samples, checks commands.
    logic [11:0] x_samp[4];
    logic [11:0] y_samp[4];
    logic [11:0] val = '0;
    logic [7:0]  cmd_rx = '0;
    logic [7:0]  exp_cmd;
    logic        prev_cs = 1'b1;
    logic        prev_dclk = 1'b0;
    int xi = 0, yi = 0, rise_n = 0, fall_n = 0, cs_falls = 0;

    always @(negedge sys_clk) begin
        if (prev_cs && !adc_cs_n) begin
            cs_falls++;
            rise_n = 0;
            fall_n = 0;
            cmd_rx = 8'h00;
        end else if (!adc_cs_n) begin
            if (!prev_dclk && adc_dclk) begin
                rise_n++;
                if (rise_n <= 8) cmd_rx = {cmd_rx[6:0], adc_din};
            end else if (prev_dclk && !adc_dclk) begin
                fall_n++;
                if (fall_n == 8) begin
                    if (cmd_rx == 8'hD0) begin val = x_samp[xi]; xi = (xi + 1) % 4; end
                    else                 begin val = y_samp[yi]; yi = (yi + 1) % 4; end
                    if (cmd_q.size() > 0) begin
                        exp_cmd = cmd_q.pop_front();
                        chk("adc_din_cmd", 32'(cmd_rx), 32'(exp_cmd));
                    end
                end
                adc_dout = (fall_n >= 9 && fall_n <= 20) ? val[20 - fall_n] : 1'b0;
            end
        end
        prev_cs   = adc_cs_n;
        prev_dclk = adc_dclk;
    end

    initial begin
        int cs0, t0, k, ten_seen;

        for (int i = 0; i < 4; i++) begin x_samp[i] = 12'hA50; y_samp[i] = 12'h3FC; end

        // Reset state
        repeat (5) @(posedge sys_clk);
        #1;
        chk("rst_cs_n", 32'(adc_cs_n), 1);
        chk("rst_dclk", 32'(adc_dclk), 0);
        chk("rst_din", 32'(adc_din), 0);
        chk("rst_x", 32'(x_coord), 0);
        chk("rst_y", 32'(y_coord), 0);
        chk("rst_new_coord", 32'(new_coord), 0);
        chk("rst_transmit_en", 32'(transmit_en), 0);
        chk("rst_penirq_n", 32'(penirq_n), 1);
        @(negedge sys_clk) iRST_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // Debounce reject: 60-cycle glitch against DEBOUNCE=100
        cs0 = cs_falls;
        ten_seen = 0;
        adc_penirq_n = 1'b0;
        repeat (60) begin @(negedge sys_clk); ten_seen |= int'(transmit_en); end
        adc_penirq_n = 1'b1;
        repeat (200) begin @(negedge sys_clk); ten_seen |= int'(transmit_en); end
        chk("debounce_reject_ten", ten_seen, 0);
        chk("debounce_reject_cs", cs_falls - cs0, 0);

        // Single touch, constant samples
        push_frame(8'hA5, 10'h0FF);
        cs0 = cs_falls;
        t0 = cyc;
        adc_penirq_n = 1'b0;
        k = 0;
        while (nc_seen < 1 && k < 3000) begin @(negedge sys_clk); k++; end
        chk("single_new_coord_seen", int'(nc_seen >= 1), 1);
        chk("single_conversions", cs_falls - cs0, 8);
        chk_range("single_latency", last_nc_cyc - t0, int'(DEB) + 8*48*CLK_DIV, int'(DEB) + 8*50*CLK_DIV + 8);
        adc_penirq_n = 1'b1;
        k = 0;
        while (transmit_en && k < 1000) begin @(negedge sys_clk); k++; end
        chk("single_release_ten", 32'(transmit_en), 0);
        chk_range("single_release_latency", cyc - last_nc_cyc, int'(REL), int'(REL) + 8);
        cs0 = cs_falls;
        repeat (300) @(negedge sys_clk);
        chk("single_no_cs_after_release", cs_falls - cs0, 0);

        // Averaging with a release during slot 3
        x_samp[0] = 12'd100;  x_samp[1] = 12'd104;  x_samp[2] = 12'd108;  x_samp[3] = 12'd112;
        y_samp[0] = 12'd1000; y_samp[1] = 12'd1001; y_samp[2] = 12'd1002; y_samp[3] = 12'd1003;
        push_frame(8'd6, 10'd250);
        cs0 = cs_falls;
        adc_penirq_n = 1'b0;
        k = 0;
        while (cs_falls - cs0 < 4 && k < 3000) begin @(negedge sys_clk); k++; end
        chk("midframe_reached_slot3", int'(cs_falls - cs0 >= 4), 1);
        adc_penirq_n = 1'b1;
        k = 0;
        while (nc_seen < 2 && k < 3000) begin @(negedge sys_clk); k++; end
        chk("midframe_new_coord_seen", int'(nc_seen >= 2), 1);
        chk("midframe_conversions", cs_falls - cs0, 8);
        k = 0;
        while (transmit_en && k < 1000) begin @(negedge sys_clk); k++; end
        chk("midframe_release_ten", 32'(transmit_en), 0);
        chk_range("midframe_release_latency", cyc - last_nc_cyc, int'(REL), int'(REL) + 8);
        cs0 = cs_falls;
        repeat (300) @(negedge sys_clk);
        chk("midframe_no_cs_after_release", cs_falls - cs0, 0);
        chk("midframe_single_strobe", nc_seen, 2);

        // Re-touch: full debounce must run before CS drops again
        cs0 = cs_falls;
        t0 = cyc;
        adc_penirq_n = 1'b0;
        k = 0;
        while (cs_falls == cs0 && k < 3000) begin @(negedge sys_clk); k++; end
        chk_range("retouch_debounce_latency", cyc - t0, int'(DEB), int'(DEB) + 10);

        // Asynchronous reset in the middle of a conversion
        repeat (30) @(negedge sys_clk);
        chk("reset_precond_cs_low", 32'(adc_cs_n), 0);
        #2 iRST_n = 1'b0;
        #1;
        chk("midrst_cs_n", 32'(adc_cs_n), 1);
        chk("midrst_dclk", 32'(adc_dclk), 0);
        chk("midrst_din", 32'(adc_din), 0);
        chk("midrst_x", 32'(x_coord), 0);
        chk("midrst_y", 32'(y_coord), 0);
        chk("midrst_transmit_en", 32'(transmit_en), 0);
        chk("midrst_penirq_n", 32'(penirq_n), 1);
        repeat (20) @(negedge sys_clk);
        chk("midrst_cs_held", 32'(adc_cs_n), 1);
        adc_penirq_n = 1'b1;
        iRST_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        chk("final_strobe_count", nc_seen, 2);
        chk("final_coord_queue_empty", exp_q.size(), 0);
        chk("final_cmd_queue_empty", cmd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
